// File: rtl/arcade_input_map.sv
// rtl/arcade_input_map.sv - joystick word to active-low arcade button conditioner
//
// Purpose: registers hps_io joystick words and maps them to per-player
// active-low button outputs with direction cleaning, coin pulse shaping
// (one queued coin), optional autofire and a global lockout.
// Ports:
//   clk_sys, reset (sync, active-high), ce (timer tick enable)
//   joy_in[16*PLAYERS]   : player p in [16p+15:16p], active-high buttons
//   cocktail             : 0 shared (OR of all pads), 1 per-player
//   autofire_en[PLAYERS] : per-channel autofire enable
//   lockout              : forces every output inactive
//   up_n..coin_n[PLAYERS]: registered active-low outputs
module arcade_input_map #(
  parameter int PLAYERS    = 2,
  parameter int COIN_PULSE = 8,
  parameter int COIN_GAP   = 8,
  parameter int AF_HALF    = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce,
  input  logic [16*PLAYERS-1:0]   joy_in,
  input  logic                    cocktail,
  input  logic [PLAYERS-1:0]      autofire_en,
  input  logic                    lockout,
  output logic [PLAYERS-1:0]      up_n,
  output logic [PLAYERS-1:0]      down_n,
  output logic [PLAYERS-1:0]      left_n,
  output logic [PLAYERS-1:0]      right_n,
  output logic [PLAYERS-1:0]      fire_n,
  output logic [PLAYERS-1:0]      bomb_n,
  output logic [PLAYERS-1:0]      start_n,
  output logic [PLAYERS-1:0]      coin_n
);

  localparam int CLOG_P = $clog2(COIN_PULSE);
  localparam int CLOG_G = $clog2(COIN_GAP);
  localparam int CW     = ((CLOG_P > CLOG_G) ? CLOG_P : CLOG_G) + 1;
  localparam int AW     = $clog2(AF_HALF) + 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);
  localparam logic [AW-1:0] AF_LAST    = AW'(AF_HALF - 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_state_t;

  logic [16*PLAYERS-1:0]      j_r;
  logic                       lock_r;
  logic [15:0]                j_or;
  logic [PLAYERS-1:0][15:0]   src;

  // Stage 1: lockout is staged alongside the pad words so both reach the
  // outputs with the same two-cycle latency.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      j_r    <= '0;
      lock_r <= 1'b0;
    end else begin
      j_r    <= joy_in;
      lock_r <= lockout;
    end
  end

  always_comb begin
    j_or = '0;
    for (int i = 0; i < PLAYERS; i++) j_or = j_or | j_r[16*i +: 16];
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_ch
    logic rt, lf, dn, upb, fire, bomb, coin_in, rise, start_req;
    logic unused_hi;

    assign src[p]    = cocktail ? j_r[16*p +: 16] : j_or;
    assign rt        = src[p][0];
    assign lf        = src[p][1];
    assign dn        = src[p][2];
    assign upb       = src[p][3];
    assign fire      = src[p][4];
    assign bomb      = src[p][5];
    assign coin_in   = src[p][8];
    assign unused_hi = ^src[p][15:7];

    // Channel 1 also starts from player 0's alt-start (2P start from one pad).
    if (p == 1) begin : g_alt
      assign start_req = src[1][6] | src[0][7];
    end else begin : g_std
      assign start_req = src[p][6];
    end

    // Autofire: phase starts at 1 so the first press fires immediately.
    logic [AW-1:0] af_cnt;
    logic          af_ph;

    always_ff @(posedge clk_sys) begin
      if (reset || lock_r || !fire || !autofire_en[p]) begin
        af_cnt <= '0;
        af_ph  <= 1'b1;
      end else if (ce) begin
        if (af_cnt == AF_LAST) begin
          af_cnt <= '0;
          af_ph  <= ~af_ph;
        end else begin
          af_cnt <= af_cnt + 1'b1;
        end
      end
    end

    // Coin FSM
    coin_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pend, pend_nx, prev, coin_nx;

    assign rise = coin_in & ~prev;

    // prev tracks through lockout so a coin held across it does not retrigger.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state <= C_IDLE;
        cnt   <= '0;
        pend  <= 1'b0;
        prev  <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        pend  <= pend_nx;
        prev  <= coin_in;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      if (lock_r) begin
        state_nx = C_IDLE;
        cnt_nx   = '0;
        pend_nx  = 1'b0;
      end else begin
        unique case (state)
          C_IDLE: begin
            if (rise) begin
              state_nx = C_PULSE;
              cnt_nx   = '0;
            end
          end
          C_PULSE: begin
            if (rise) pend_nx = 1'b1;
            if (ce) begin
              if (cnt == PULSE_LAST) begin
                state_nx = C_GAP;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt + 1'b1;
              end
            end
          end
          C_GAP: begin
            if (ce && cnt == GAP_LAST) begin
              // An edge landing on the expiry cycle is treated as pending.
              cnt_nx = '0;
              if (pend || rise) begin
                state_nx = C_PULSE;
                pend_nx  = 1'b0;
              end else begin
                state_nx = C_IDLE;
              end
            end else begin
              if (ce) cnt_nx = cnt + 1'b1;
              if (rise) pend_nx = 1'b1;
            end
          end
          default: begin
            state_nx = C_IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    always_comb begin
      coin_nx = (state_nx != C_PULSE);
    end

    // Output register: {coin, start, bomb, fire, right, left, down, up}
    logic [7:0] out_q;

    always_ff @(posedge clk_sys) begin
      if (reset || lock_r) begin
        out_q <= '1;
      end else begin
        out_q <= {coin_nx,
                  ~start_req,
                  ~bomb,
                  ~(fire & (af_ph | ~autofire_en[p])),
                  ~(rt & ~lf),
                  ~(lf & ~rt),
                  ~(dn & ~upb),
                  ~(upb & ~dn)};
      end
    end

    assign up_n[p]    = out_q[0];
    assign down_n[p]  = out_q[1];
    assign left_n[p]  = out_q[2];
    assign right_n[p] = out_q[3];
    assign fire_n[p]  = out_q[4];
    assign bomb_n[p]  = out_q[5];
    assign start_n[p] = out_q[6];
    assign coin_n[p]  = out_q[7];
  end

endmodule

// File: tb/tb_arcade_input_map.sv
// tb/tb_arcade_input_map.sv - self-checking bench for arcade_input_map
module tb_arcade_input_map;
  localparam int PLAYERS    = 2;
  localparam int COIN_PULSE = 8;
  localparam int COIN_GAP   = 8;
  localparam int AF_HALF    = 4;

  logic                  clk_sys = 1'b0;
  logic                  reset, ce, cocktail, lockout;
  logic [16*PLAYERS-1:0] joy_in;
  logic [PLAYERS-1:0]    autofire_en;
  logic [PLAYERS-1:0]    up_n, down_n, left_n, right_n, fire_n, bomb_n, start_n, coin_n;

  always #5 clk_sys = ~clk_sys;

  arcade_input_map #(
    .PLAYERS(PLAYERS), .COIN_PULSE(COIN_PULSE), .COIN_GAP(COIN_GAP), .AF_HALF(AF_HALF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .joy_in(joy_in), .cocktail(cocktail),
    .autofire_en(autofire_en), .lockout(lockout),
    .up_n(up_n), .down_n(down_n), .left_n(left_n), .right_n(right_n),
    .fire_n(fire_n), .bomb_n(bomb_n), .start_n(start_n), .coin_n(coin_n)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: expected outputs after each clock edge.
  logic [16*PLAYERS-1:0] jr_m;
  logic                  lock_m;
  logic [PLAYERS-1:0]    e_up, e_down, e_left, e_right, e_fire, e_bomb, e_start, e_coin;
  int                    rem      [PLAYERS];  // ce ticks left in the pulse+gap window
  bit                    pend_m   [PLAYERS];
  bit                    prev_m   [PLAYERS];
  int                    af_ticks [PLAYERS];  // ce ticks fire has been held with autofire on

  task model_step();
    logic [15:0] s [PLAYERS];
    logic [15:0] any;
    bit          rise, fire_on;
    if (reset) begin
      jr_m = '0; lock_m = 1'b0;
      e_up = '1; e_down = '1; e_left = '1; e_right = '1;
      e_fire = '1; e_bomb = '1; e_start = '1; e_coin = '1;
      for (int p = 0; p < PLAYERS; p++) begin
        rem[p] = 0; pend_m[p] = 0; prev_m[p] = 0; af_ticks[p] = 0;
      end
      return;
    end
    any = '0;
    for (int p = 0; p < PLAYERS; p++) any = any | jr_m[16*p +: 16];
    for (int p = 0; p < PLAYERS; p++) s[p] = cocktail ? jr_m[16*p +: 16] : any;
    for (int p = 0; p < PLAYERS; p++) begin
      fire_on = s[p][4] && (!autofire_en[p] || ((af_ticks[p] / AF_HALF) % 2 == 0));
      if (lock_m) begin
        e_up[p] = 1; e_down[p] = 1; e_left[p] = 1; e_right[p] = 1;
        e_fire[p] = 1; e_bomb[p] = 1; e_start[p] = 1;
      end else begin
        e_right[p] = !(s[p][0] && !s[p][1]);
        e_left[p]  = !(s[p][1] && !s[p][0]);
        e_down[p]  = !(s[p][2] && !s[p][3]);
        e_up[p]    = !(s[p][3] && !s[p][2]);
        e_bomb[p]  = !s[p][5];
        e_start[p] = !(s[p][6] || (p == 1 && s[0][7]));
        e_fire[p]  = !fire_on;
      end
      if (lock_m || !s[p][4] || !autofire_en[p]) af_ticks[p] = 0;
      else if (ce) af_ticks[p]++;

      rise = s[p][8] && !prev_m[p];
      if (lock_m) begin
        rem[p] = 0; pend_m[p] = 0;
      end else if (rem[p] == 0) begin
        if (rise) rem[p] = COIN_PULSE + COIN_GAP;
      end else begin
        if (ce) rem[p]--;
        if (rem[p] == 0) begin
          if (pend_m[p] || rise) begin
            rem[p] = COIN_PULSE + COIN_GAP;
            pend_m[p] = 0;
          end
        end else if (rise) begin
          pend_m[p] = 1;
        end
      end
      e_coin[p] = lock_m ? 1'b1 : !(rem[p] > COIN_GAP);
      prev_m[p] = s[p][8];
    end
    jr_m = joy_in;
    lock_m = lockout;
  endtask

  task step();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    cyc++;
    check("up_n", 32'(up_n), 32'(e_up));
    check("down_n", 32'(down_n), 32'(e_down));
    check("left_n", 32'(left_n), 32'(e_left));
    check("right_n", 32'(right_n), 32'(e_right));
    check("fire_n", 32'(fire_n), 32'(e_fire));
    check("bomb_n", 32'(bomb_n), 32'(e_bomb));
    check("start_n", 32'(start_n), 32'(e_start));
    check("coin_n", 32'(coin_n), 32'(e_coin));
  endtask

  task steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int lows, falls;
  logic last_coin;

  initial begin
    reset = 1; ce = 1; cocktail = 0; lockout = 0; joy_in = '0; autofire_en = '0;
    steps(2);
    check("rst_all_outputs", 32'({up_n, down_n, left_n, right_n, fire_n, bomb_n, start_n, coin_n}), 32'h0000_FFFF);
    reset = 0;
    steps(2);

    // Shared mode: player 1 up drives both channels.
    joy_in = 32'h0008_0000;
    steps(2);
    check("shared_up", 32'(up_n), 32'h0);
    joy_in = 32'h0000_0003;
    steps(2);
    check("lr_clean_left", 32'(left_n), 32'h3);
    check("lr_clean_right", 32'(right_n), 32'h3);

    // Cocktail mode: per-player fire/bomb; p0 alt-start starts channel 1.
    cocktail = 1;
    joy_in = 32'h0020_0010;
    steps(2);
    check("ck_fire", 32'(fire_n), 32'h2);
    check("ck_bomb", 32'(bomb_n), 32'h1);
    joy_in = 32'h0000_0080;
    steps(2);
    check("ck_alt_start", 32'(start_n), 32'h1);
    joy_in = '0;
    steps(3);

    // Three quick coin taps: two pulses, third dropped.
    lows = 0; falls = 0; last_coin = 1;
    for (int i = 0; i < 45; i++) begin
      joy_in = (i < 5 && i % 2 == 0) ? 32'h0000_0100 : 32'h0;
      step();
      if (!coin_n[0]) lows++;
      if (last_coin && !coin_n[0]) falls++;
      last_coin = coin_n[0];
    end
    check("coin_tap_lows", 32'(lows), 32'd16);
    check("coin_tap_pulses", 32'(falls), 32'd2);

    // Autofire on player 0, fire held 20 cycles.
    autofire_en = 2'b01;
    joy_in = 32'h0000_0010;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!fire_n[0]) lows++;
    end
    check("af_lows", 32'(lows), 32'd11);
    autofire_en = 2'b00;
    steps(3);
    check("af_off_steady", 32'(fire_n[0]), 32'h0);
    joy_in = '0;
    steps(3);

    // Coin held through lockout must not produce a new pulse.
    joy_in = 32'h0000_0100;
    steps(25);
    lockout = 1;
    steps(10);
    lockout = 0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!coin_n[0]) lows++;
    end
    check("lockout_no_coin", 32'(lows), 32'd0);
    joy_in = '0;
    steps(3);
    joy_in = 32'h0000_0100;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!coin_n[0]) lows++;
    end
    check("repress_coin", 32'(lows), 32'd8);
    joy_in = '0;
    steps(20);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      ce = (i < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int p = 0; p < PLAYERS; p++)
        if ($urandom_range(0, 7) == 0) joy_in[16*p +: 16] = 16'($urandom) & 16'h01FF;
      if ($urandom_range(0, 199) == 0) cocktail = ~cocktail;
      if ($urandom_range(0, 99) == 0) lockout = ~lockout;
      if ($urandom_range(0, 49) == 0) autofire_en = PLAYERS'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; lockout = 0; ce = 1;
    steps(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
